// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: latches decoded fields plus resolved operands, with writeback bypass and load-use stall.
// Optional ID_EX_STALL_COUNT_EN adds a saturating count of inserted load-use bubbles on stall_count.
module id_ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int OPC_W  = 4,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_W-1:0]  id_dst,
    input  logic              id_we,
    input  logic              id_memread,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_hold,
    input  logic              flush,
`ifdef ID_EX_STALL_COUNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic              stall_id,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_src1_idx,
    output logic [REG_W-1:0]  ex_src2_idx,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [REG_W-1:0]  ex_dst,
    output logic              ex_we,
    output logic              ex_memread,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic [IMM_W-1:0]  ex_imm
);

    logic              r_valid;
    logic [REG_W-1:0]  r_src1_idx;
    logic [REG_W-1:0]  r_src2_idx;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [REG_W-1:0]  r_dst;
    logic              r_we;
    logic              r_memread;
    logic [OPC_W-1:0]  r_opcode;
    logic [IMM_W-1:0]  r_imm;

    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_hazard;
    logic              w_snoop1;
    logic              w_snoop2;

    // The register file has no internal bypass, so a same-cycle writeback must be forwarded here.
    always_comb begin
        w_op1 = rf_data1;
        if (id_src1 == '0)
            w_op1 = '0;
        else if (wb_we && (wb_dst == id_src1))
            w_op1 = wb_data;

        w_op2 = rf_data2;
        if (id_src2 == '0)
            w_op2 = '0;
        else if (wb_we && (wb_dst == id_src2))
            w_op2 = wb_data;
    end

    assign w_hazard = r_valid && r_memread && r_we && (r_dst != '0) && id_valid &&
                      ((id_use1 && (id_src1 == r_dst)) || (id_use2 && (id_src2 == r_dst)));

    assign w_snoop1 = (r_src1_idx != '0) && wb_we && (wb_dst == r_src1_idx);
    assign w_snoop2 = (r_src2_idx != '0) && wb_we && (wb_dst == r_src2_idx);

    assign stall_id = w_hazard || ex_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_src1_idx <= '0;
            r_src2_idx <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_dst      <= '0;
            r_we       <= 1'b0;
            r_memread  <= 1'b0;
            r_opcode   <= '0;
            r_imm      <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_memread <= 1'b0;
        end else if (ex_hold) begin
            // Held operands keep tracking writebacks so they are not stale on release.
            if (w_snoop1)
                r_op1 <= wb_data;
            if (w_snoop2)
                r_op2 <= wb_data;
        end else if (w_hazard) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_memread <= 1'b0;
        end else begin
            r_valid    <= id_valid;
            r_src1_idx <= id_src1;
            r_src2_idx <= id_src2;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_dst      <= id_dst;
            r_we       <= id_we && id_valid;
            r_memread  <= id_memread && id_valid;
            r_opcode   <= id_opcode;
            r_imm      <= id_imm;
        end
    end

`ifdef ID_EX_STALL_COUNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_count <= '0;
        else if (!flush && !ex_hold && w_hazard && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'd1;
    end

    assign stall_count = r_stall_count;
`endif

    assign ex_valid    = r_valid;
    assign ex_src1_idx = r_src1_idx;
    assign ex_src2_idx = r_src2_idx;
    assign ex_op1      = r_op1;
    assign ex_op2      = r_op2;
    assign ex_dst      = r_dst;
    assign ex_we       = r_we;
    assign ex_memread  = r_memread;
    assign ex_opcode   = r_opcode;
    assign ex_imm      = r_imm;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, bypass, load-use, hold snoop, flush priority, optional stall counter.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1, id_src2, id_dst;
    logic        id_use1, id_use2, id_we, id_memread;
    logic [3:0]  id_opcode;
    logic [15:0] id_imm, rf_data1, rf_data2;
    logic        wb_we;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        ex_hold, flush;
    logic        stall_id, ex_valid, ex_we, ex_memread;
    logic [3:0]  ex_src1_idx, ex_src2_idx, ex_dst, ex_opcode;
    logic [15:0] ex_op1, ex_op2, ex_imm;
`ifdef ID_EX_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .id_dst(id_dst),
        .id_we(id_we), .id_memread(id_memread), .id_opcode(id_opcode), .id_imm(id_imm),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .ex_hold(ex_hold), .flush(flush),
`ifdef ID_EX_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_src1_idx(ex_src1_idx), .ex_src2_idx(ex_src2_idx),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_dst(ex_dst),
        .ex_we(ex_we), .ex_memread(ex_memread),
        .ex_opcode(ex_opcode), .ex_imm(ex_imm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2, input logic [3:0] d,
                          input logic we, input logic mr, input logic [3:0] opc,
                          input logic [15:0] imm, input logic [15:0] d1, input logic [15:0] d2);
        id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
        id_dst = d; id_we = we; id_memread = mr; id_opcode = opc; id_imm = imm;
        rf_data1 = d1; rf_data2 = d2;
    endtask

    task automatic set_wb(input logic we, input logic [3:0] d, input logic [15:0] data);
        wb_we = we; wb_dst = d; wb_data = data;
    endtask

    initial begin
        // Reset with scrambled inputs
        rst = 1'b1; ex_hold = 1'b0; flush = 1'b0;
        set_id(1'b1, 4'($urandom), 1'b1, 4'($urandom), 1'b1, 4'($urandom), 1'b1, 1'b1,
               4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        set_wb(1'b1, 4'($urandom), 16'($urandom));
        step();
        step();
        check("rst_valid",   ex_valid,    0);
        check("rst_op1",     ex_op1,      0);
        check("rst_op2",     ex_op2,      0);
        check("rst_dst",     ex_dst,      0);
        check("rst_we",      ex_we,       0);
        check("rst_memread", ex_memread,  0);
        check("rst_opcode",  ex_opcode,   0);
        check("rst_imm",     ex_imm,      0);
        check("rst_src1",    ex_src1_idx, 0);
        check("rst_src2",    ex_src2_idx, 0);
        check("rst_stall",   stall_id,    0);
`ifdef ID_EX_STALL_COUNT_EN
        check("rst_count",   stall_count, 0);
`endif
        rst = 1'b0;

        // Writeback bypass onto src1
        set_id(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd6, 1'b1, 1'b0, 4'd5, 16'hFFF0, 16'h1111, 16'h2222);
        set_wb(1'b1, 4'd3, 16'hBEEF);
        step();
        check("byp_valid",  ex_valid,    1);
        check("byp_op1",    ex_op1,      16'hBEEF);
        check("byp_op2",    ex_op2,      16'h2222);
        check("byp_dst",    ex_dst,      6);
        check("byp_we",     ex_we,       1);
        check("byp_opcode", ex_opcode,   5);
        check("byp_imm",    ex_imm,      16'hFFF0);
        check("byp_src1",   ex_src1_idx, 3);

        // R0 never bypasses and always reads zero
        set_id(1'b1, 4'd0, 1'b1, 4'd4, 1'b1, 4'd6, 1'b1, 1'b0, 4'd5, 16'h0001, 16'h1234, 16'h2222);
        set_wb(1'b1, 4'd0, 16'hDEAD);
        step();
        check("r0_op1", ex_op1, 0);

        // Load R5, then dependent use of src2
        set_wb(1'b0, 4'd0, 16'h0000);
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b1, 4'd1, 16'h0000, 16'h0101, 16'h0202);
        step();
        check("ld_memread", ex_memread, 1);
        check("ld_dst",     ex_dst,     5);
        set_id(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd8, 1'b1, 1'b0, 4'd3, 16'h0010, 16'h0000, 16'h5555);
        #1;
        check("lu_stall", stall_id, 1);
        step();
        check("lu_bubble_valid", ex_valid,   0);
        check("lu_bubble_we",    ex_we,      0);
        check("lu_bubble_mr",    ex_memread, 0);
        check("lu_stall_clear",  stall_id,   0);
        set_wb(1'b1, 4'd5, 16'h7777);
        step();
        check("lu_valid", ex_valid, 1);
        check("lu_op2",   ex_op2,   16'h7777);
        check("lu_dst",   ex_dst,   8);

        // Same load, but src2 not used: no stall
        set_wb(1'b0, 4'd0, 16'h0000);
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b1, 4'd1, 16'h0000, 16'h0101, 16'h0202);
        step();
        set_id(1'b1, 4'd9, 1'b1, 4'd5, 1'b0, 4'd8, 1'b1, 1'b0, 4'd3, 16'h0010, 16'h0909, 16'h5555);
        #1;
        check("nouse_stall", stall_id, 0);
        step();
        check("nouse_valid", ex_valid,    1);
        check("nouse_src2",  ex_src2_idx, 5);

        // Hold with writeback snoop on a held source
        set_id(1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0, 4'hA, 16'h0042, 16'h0001, 16'h0022);
        step();
        check("hold_pre_op1", ex_op1, 16'h0001);
        ex_hold = 1'b1;
        set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd4, 1'b0, 1'b0, 4'h1, 16'h9999, 16'hFFFF, 16'hFFFF);
        #1;
        check("hold_stall", stall_id, 1);
        step();
        check("hold_c1_op1", ex_op1, 16'h0001);
        set_wb(1'b1, 4'd7, 16'h00AA);
        step();
        check("hold_c2_op1", ex_op1, 16'h00AA);
        set_wb(1'b0, 4'd0, 16'h0000);
        step();
        check("hold_c3_op1",  ex_op1,      16'h00AA);
        check("hold_op2",     ex_op2,      16'h0022);
        check("hold_dst",     ex_dst,      9);
        check("hold_opcode",  ex_opcode,   4'hA);
        check("hold_imm",     ex_imm,      16'h0042);
        check("hold_src1",    ex_src1_idx, 7);
        check("hold_valid",   ex_valid,    1);
        check("hold_we",      ex_we,       1);

        // Flush overrides hold
        flush = 1'b1;
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 4'h2, 16'h0000, 16'h0001, 16'h0002);
        step();
        check("flush_valid", ex_valid, 0);
        check("flush_we",    ex_we,    0);
        flush = 1'b0;
        ex_hold = 1'b0;

`ifdef ID_EX_STALL_COUNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_id(1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'h1, 16'h0000, 16'h0000, 16'h0000);
            step();
            set_id(1'b1, 4'd5, 1'b1, 4'd2, 1'b0, 4'd6, 1'b1, 1'b0, 4'h2, 16'h0000, 16'h0000, 16'h0000);
            if (k == 2) begin
                ex_hold = 1'b1;
                step();
                ex_hold = 1'b0;
                flush = 1'b1;
                step();
                flush = 1'b0;
            end else begin
                step();
            end
        end
        check("cnt_three", stall_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cnt_rst", stall_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
